crc_rx_check: RTL and testbench
===============================

CRC_RX_CHECK -- requirements
Module: crc_rx_check

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 The clock and reset ports SHALL be: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-003 rx_in  input  1  serial PHR/PSDU bit, LSB of each byte first.
REQ-004 rx_in_valid  input  1  frame envelope; each clk cycle with rx_in_valid high carries exactly one bit.
REQ-005 rx_byte  output  8  recovered data byte.
REQ-006 rx_byte_valid  output  1  one-cycle strobe qualifying rx_byte.
REQ-007 rx_len  output  7  count of data bytes delivered in the last frame, FCS excluded.
REQ-008 frame_done  output  1  one-cycle strobe at end of frame.
REQ-009 crc_ok  output  1  last frame passed the FCS check; valid with frame_done and held until the next frame_done.
REQ-010 frame_err  output  1  last frame was malformed; valid with frame_done and held until the next frame_done.
REQ-011 Parameter MAX_BYTES, default 127, SHALL set the maximum data bytes per frame, FCS excluded.

Function
REQ-012 The FSM SHALL have two states, IDLE and RECV.
REQ-013 IDLE->RECV: rx_in_valid=1; that cycle's bit SHALL be the first bit, with the CRC register cleared to 16'h0000 and the bit counter cleared before it is absorbed.
REQ-014 RECV->RECV: rx_in_valid=1; shift in rx_in, increment bit counter.
REQ-015 RECV->IDLE: first cycle with rx_in_valid=0; frame_done SHALL pulse 1 cycle later.
REQ-016 CRC SHALL be CRC-16 ITU-T, x^16+x^12+x^5+1, init 16'h0000, no final XOR, LSB-first reflected LFSR, computed over all bits including the FCS.
REQ-017 Pass condition SHALL be residual == 16'h0000, which matches the 2-byte FCS appended by the TX crc block.
REQ-018 Bits SHALL be assembled into bytes LSB-first, with bit 0 being the first received.
REQ-019 The last 16 received bits are the FCS and SHALL never appear on rx_byte; this is met with a 2-byte delay line.
REQ-020 A byte SHALL be emitted (rx_byte_valid=1) one cycle after the cycle that absorbs bit 8k+24 (k=0,1,...), i.e. once 16 further bits follow it.
REQ-021 rx_byte SHALL be stable only while rx_byte_valid=1; there is no back-pressure.
REQ-022 At frame_done, crc_ok SHALL be 1 iff residual==0 and frame_err==0.
REQ-023 At frame_done, frame_err SHALL be 1 if the bit count is not a multiple of 8, or fewer than 24 bits (1 data byte + FCS) were received, or the data-byte count exceeds MAX_BYTES.
REQ-024 Overlength: once data bytes exceed MAX_BYTES, further rx_byte_valid strobes SHALL be suppressed, rx_len SHALL saturate at MAX_BYTES, and frame_err=1 at frame_done.
REQ-025 A trailing partial byte (length not a multiple of 8) SHALL NOT be emitted.
REQ-026 rx_len SHALL update at frame_done.
REQ-027 Back-to-back frames: rx_in_valid high again in the cycle that frame_done pulses SHALL start a new frame with no lost bit.
REQ-028 A rx_in_valid gap of at least 1 cycle SHALL always terminate the frame.
REQ-029 Latency SHALL be: rx_byte_valid 1 cycle after its qualifying bit; frame_done 1 cycle after rx_in_valid falls.

Reset
REQ-030 While reset=1 at a clk edge, the block SHALL enter IDLE; CRC and counters SHALL clear; rx_byte=8'h00, rx_byte_valid=0, rx_len=0, frame_done=0, crc_ok=0, frame_err=0.
REQ-031 Reset mid-frame SHALL abort the frame with no frame_done; after reset deasserts, the next rx_in_valid high SHALL start a fresh frame.
REQ-032 Reset SHALL take priority over rx_in_valid in the same cycle.

Verification
REQ-033 Serial bits 01000000 00000000 01010110 0010011110011110 (bytes 02 00 6A, FCS) -> rx_byte 02, 00, 6A; rx_len=3; crc_ok=1; frame_err=0.
REQ-034 Same frame with one data bit inverted -> 3 bytes emitted, crc_ok=0, frame_err=0.
REQ-035 Frame of 30 bits -> 1 byte emitted, frame_err=1, crc_ok=0.
REQ-036 16-bit frame -> no rx_byte_valid, rx_len=0, frame_err=1.
REQ-037 The REQ-033 frame sent twice with 1 idle cycle between -> two frame_done pulses, both crc_ok=1.
REQ-038 reset=1 after 12 bits of a frame, then a valid frame -> no frame_done for the aborted frame, second frame crc_ok=1, and all outputs 0 during reset.

Source files
------------

// File: rtl/crc_rx_check.sv
// Serial CRC-16 (ITU-T, reflected) frame receiver: assembles LSB-first bytes,
// withholds the trailing 2-byte FCS via a delay line and reports the check at frame end.
module crc_rx_check #(
    parameter int unsigned MAX_BYTES = 127
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_in_valid,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic [6:0] rx_len,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       frame_err
);

    localparam int unsigned CNT_W   = $clog2(MAX_BYTES + 4);
    localparam int unsigned CRC_W   = 16;
    localparam int unsigned SHIFT_W = 24;
    localparam logic [CRC_W-1:0] POLY_REFL = 16'h8408;

    typedef enum logic {IDLE, RECV} state_e;

    state_e             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d, crc_base;
    logic [SHIFT_W-1:0] sh_q, sh_d;
    logic [2:0]         bitpos_q, bitpos_d, bitpos_base;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d, byte_base;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic               rx_byte_valid_q, rx_byte_valid_d;
    logic [6:0]         rx_len_q, rx_len_d;
    logic               frame_done_q, frame_done_d;
    logic               crc_ok_q, crc_ok_d;
    logic               frame_err_q, frame_err_d;
    logic               fb;
    logic               err;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_in_valid)  state_d = RECV;
            RECV:    if (!rx_in_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next-values; a frame's first bit starts from cleared counters/CRC
    always_comb begin
        crc_d           = crc_q;
        sh_d            = sh_q;
        bitpos_d        = bitpos_q;
        byte_cnt_d      = byte_cnt_q;
        rx_byte_d       = rx_byte_q;
        rx_byte_valid_d = 1'b0;
        rx_len_d        = rx_len_q;
        frame_done_d    = 1'b0;
        crc_ok_d        = crc_ok_q;
        frame_err_d     = frame_err_q;
        fb              = 1'b0;
        err             = 1'b0;
        crc_base        = (state_q == IDLE) ? '0 : crc_q;
        bitpos_base     = (state_q == IDLE) ? '0 : bitpos_q;
        byte_base       = (state_q == IDLE) ? '0 : byte_cnt_q;

        if (rx_in_valid) begin
            fb       = crc_base[0] ^ rx_in;
            crc_d    = {1'b0, crc_base[CRC_W-1:1]} ^ (fb ? POLY_REFL : '0);
            sh_d     = {rx_in, sh_q[SHIFT_W-1:1]};
            bitpos_d = bitpos_base + 3'd1;
            byte_cnt_d = byte_base;
            if (bitpos_base == 3'd7) begin
                if (byte_base != CNT_W'(MAX_BYTES + 3))
                    byte_cnt_d = byte_base + CNT_W'(1);
                // Byte completing now has two more bytes behind it: oldest is data
                if (byte_base >= CNT_W'(2) && byte_base < CNT_W'(MAX_BYTES + 2)) begin
                    rx_byte_d       = sh_d[7:0];
                    rx_byte_valid_d = 1'b1;
                end
            end
        end else if (state_q == RECV) begin
            err = (bitpos_q != 3'd0) || (byte_cnt_q < CNT_W'(3))
                  || (byte_cnt_q > CNT_W'(MAX_BYTES + 2));
            frame_done_d = 1'b1;
            frame_err_d  = err;
            crc_ok_d     = (crc_q == '0) && !err;
            if (byte_cnt_q < CNT_W'(2))
                rx_len_d = '0;
            else if (byte_cnt_q > CNT_W'(MAX_BYTES + 2))
                rx_len_d = 7'(MAX_BYTES);
            else
                rx_len_d = 7'(byte_cnt_q - CNT_W'(2));
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q           <= '0;
            sh_q            <= '0;
            bitpos_q        <= '0;
            byte_cnt_q      <= '0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            rx_len_q        <= '0;
            frame_done_q    <= 1'b0;
            crc_ok_q        <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            crc_q           <= crc_d;
            sh_q            <= sh_d;
            bitpos_q        <= bitpos_d;
            byte_cnt_q      <= byte_cnt_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            rx_len_q        <= rx_len_d;
            frame_done_q    <= frame_done_d;
            crc_ok_q        <= crc_ok_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign rx_len        = rx_len_q;
    assign frame_done    = frame_done_q;
    assign crc_ok        = crc_ok_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_crc_rx_check.sv
// Scoreboard bench for crc_rx_check: stimulus pushes expected bytes/frame results,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_crc_rx_check;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       rx_in_valid;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic [6:0] rx_len;
    logic       frame_done;
    logic       crc_ok;
    logic       frame_err;

    typedef struct {
        int len;
        bit ok;
        bit err;
    } frm_t;

    logic [7:0] exp_b[$];
    frm_t       exp_f[$];
    int checks = 0;
    int errors = 0;

    // Reference frame: data 02 00 6A followed by FCS E4 79, written first-bit-leftmost
    localparam logic [39:0] FRAME_OK  = 40'b0100000000000000010101100010011110011110;
    localparam logic [39:0] FRAME_BAD = 40'b1100000000000000010101100010011110011110;

    crc_rx_check dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .rx_in_valid  (rx_in_valid),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .rx_len       (rx_len),
        .frame_done   (frame_done),
        .crc_ok       (crc_ok),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every strobe against the head of the matching queue
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_byte_valid) begin
                if (exp_b.size() == 0) chk("unexpected_rx_byte_valid", 1, 0);
                else                   chk("rx_byte", int'(rx_byte), int'(exp_b.pop_front()));
            end
            if (frame_done) begin
                if (exp_f.size() == 0) begin
                    chk("unexpected_frame_done", 1, 0);
                end else begin
                    frm_t f;
                    f = exp_f.pop_front();
                    chk("rx_len", int'(rx_len), f.len);
                    chk("crc_ok", int'(crc_ok), int'(f.ok));
                    chk("frame_err", int'(frame_err), int'(f.err));
                end
            end
        end
    end

    task automatic idle(input int n);
        rx_in_valid = 1'b0;
        rx_in       = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send the top n bits of vec, leftmost first
    task automatic send_bits(input logic [39:0] vec, input int n);
        for (int i = 39; i > 39 - n; i--) begin
            rx_in       = vec[i];
            rx_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_in_valid = 1'b0;
    endtask

    task automatic send_zeros(input int nbytes);
        for (int i = 0; i < nbytes * 8; i++) begin
            rx_in       = 1'b0;
            rx_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_in_valid = 1'b0;
    endtask

    task automatic push_frame(input int len, input bit ok, input bit err);
        frm_t f;
        f.len = len;
        f.ok  = ok;
        f.err = err;
        exp_f.push_back(f);
    endtask

    task automatic push_ok_bytes();
        exp_b.push_back(8'h02);
        exp_b.push_back(8'h00);
        exp_b.push_back(8'h6A);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rx_byte"}, int'(rx_byte), 0);
        chk({tag, "_rx_byte_valid"}, int'(rx_byte_valid), 0);
        chk({tag, "_rx_len"}, int'(rx_len), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_crc_ok"}, int'(crc_ok), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
    endtask

    initial begin
        reset       = 1'b1;
        rx_in       = 1'b0;
        rx_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // Good frame
        push_ok_bytes();
        push_frame(3, 1'b1, 1'b0);
        send_bits(FRAME_OK, 40);
        idle(3);

        // One data bit inverted
        exp_b.push_back(8'h03);
        exp_b.push_back(8'h00);
        exp_b.push_back(8'h6A);
        push_frame(3, 1'b0, 1'b0);
        send_bits(FRAME_BAD, 40);
        idle(3);

        // 30-bit frame: one byte, not byte-aligned
        exp_b.push_back(8'h02);
        push_frame(1, 1'b0, 1'b1);
        send_bits(FRAME_OK, 30);
        idle(3);

        // 16-bit frame: FCS only
        push_frame(0, 1'b0, 1'b1);
        send_bits(FRAME_OK, 16);
        idle(3);

        // Back-to-back with a single idle cycle
        push_ok_bytes();
        push_frame(3, 1'b1, 1'b0);
        push_ok_bytes();
        push_frame(3, 1'b1, 1'b0);
        send_bits(FRAME_OK, 40);
        idle(1);
        send_bits(FRAME_OK, 40);
        idle(3);

        // Minimum frame: one zero byte with zero FCS
        exp_b.push_back(8'h00);
        push_frame(1, 1'b1, 1'b0);
        send_zeros(3);
        idle(3);

        // Exactly MAX_BYTES data bytes (all zero, FCS zero)
        for (int k = 0; k < 127; k++) exp_b.push_back(8'h00);
        push_frame(127, 1'b1, 1'b0);
        send_zeros(129);
        idle(3);

        // Overlength: 130 data bytes, strobes stop at 127
        for (int k = 0; k < 127; k++) exp_b.push_back(8'h00);
        push_frame(127, 1'b0, 1'b1);
        send_zeros(132);
        idle(3);

        // Reset after 12 bits, with rx_in_valid still high
        send_bits(FRAME_OK, 12);
        rx_in_valid = 1'b1;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        check_all_zero("midreset2");
        reset       = 1'b0;
        rx_in_valid = 1'b0;
        idle(2);
        push_ok_bytes();
        push_frame(3, 1'b1, 1'b0);
        send_bits(FRAME_OK, 40);
        idle(3);

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 50 && (exp_b.size() != 0 || exp_f.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("pending_bytes", exp_b.size(), 0);
        chk("pending_frames", exp_f.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
